// File: rtl/gb_pkg.sv
// Shared DMG core constants and types used by the OAM DMA sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package gb_pkg;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam int          OAM_DMA_LEN  = 160;
    localparam logic [7:0]  ECHO_PAGE_LO = 8'hE0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2
    } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA sequencer: FF46 write copies LEN bytes from {page, idx} into OAM, one byte per M-cycle.
// Latency: first OAM write follows the (START_DELAY+1)th mcyc_ce after the FF46 write, last one the (START_DELAY+LEN)th.
// Backpressure: none; progress is paced purely by mcyc_ce, and a new FF46 write restarts the copy at any time.
module oam_dma
    import gb_pkg::*;
#(
    parameter int LEN         = OAM_DMA_LEN,
    parameter int START_DELAY = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_mcyc_ce,
    input  logic        i_reg_we,
    input  logic [7:0]  i_reg_wdata,
    output logic [7:0]  o_reg_rdata,
    output logic [15:0] o_src_addr,
    output logic        o_src_re,
    input  logic [7:0]  i_src_rdata,
    output logic [7:0]  o_oam_addr,
    output logic [7:0]  o_oam_wdata,
    output logic        o_oam_we,
    output logic        o_busy,
    output logic        o_oam_lock
);

    localparam int               DLY_W    = $clog2(START_DELAY + 1);
    localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(START_DELAY);
    localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);
    localparam logic [7:0]       LAST_IDX = 8'(LEN - 1);

    dma_state_t       r_state;
    logic [7:0]       r_page;
    logic [7:0]       r_idx;
    logic [DLY_W-1:0] r_dly;
    logic             r_restart;
    logic [7:0]       r_oam_addr;
    logic [7:0]       r_oam_wdata;
    logic             r_oam_we;

    logic [7:0]       w_page_eff;
    logic             w_xfer;
    logic             w_hold;

    // Echo RAM (E000-FDFF) mirrors work RAM, so those pages are redirected 8 KiB down.
    always_comb begin
        w_page_eff = r_page;
        if (r_page >= ECHO_PAGE_LO) begin
            w_page_eff = r_page - 8'h20;
        end
    end

    assign w_xfer = (r_state == XFER);
    // A restart keeps the bus granted through the start delay so the CPU never sees a gap.
    assign w_hold = w_xfer || ((r_state == WAIT) && r_restart);

    assign o_reg_rdata = r_page;
    assign o_src_re    = w_xfer;
    assign o_src_addr  = w_xfer ? {w_page_eff, r_idx} : 16'h0000;
    assign o_busy      = w_hold;
    assign o_oam_lock  = w_hold;
    assign o_oam_addr  = r_oam_addr;
    assign o_oam_wdata = r_oam_wdata;
    assign o_oam_we    = r_oam_we;

    // Sequencer state, page register, start-delay and byte-index counters; FF46 writes win over mcyc_ce.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_page    <= 8'hFF;
            r_idx     <= 8'h00;
            r_dly     <= '0;
            r_restart <= 1'b0;
        end else if (i_reg_we) begin
            r_state   <= WAIT;
            r_page    <= i_reg_wdata;
            r_idx     <= 8'h00;
            r_dly     <= DLY_INIT;
            r_restart <= w_hold;
        end else if (i_mcyc_ce) begin
            case (r_state)
                WAIT: begin
                    r_dly <= r_dly - DLY_ONE;
                    if (r_dly == DLY_ONE) begin
                        r_state <= XFER;
                    end
                end
                XFER: begin
                    if (r_idx == LAST_IDX) begin
                        r_state   <= IDLE;
                        r_restart <= 1'b0;
                    end else begin
                        r_idx <= r_idx + 8'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // OAM write port: capture the source byte at the end of each transfer M-cycle, strobe for one clk.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_oam_we    <= 1'b0;
            r_oam_addr  <= 8'h00;
            r_oam_wdata <= 8'h00;
        end else begin
            r_oam_we <= 1'b0;
            if (!i_reg_we && i_mcyc_ce && w_xfer) begin
                r_oam_we    <= 1'b1;
                r_oam_addr  <= r_idx;
                r_oam_wdata <= i_src_rdata;
            end
        end
    end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- OAM DMA sequencer for the DMG core, instantiated inside dmg_main next to the CPU bus arbiter.
- A CPU write to FF46 triggers a copy of LEN bytes from source page {page, 00..LEN-1} into OAM FE00..FE00+LEN-1, at one byte per M-cycle.
- While the copy runs, `busy` tells the arbiter to give the external/work-RAM bus to the DMA and restrict the CPU to HRAM.
- `oam_lock` blocks PPU and CPU access to OAM.

Parameters:
- LEN, 160, number of bytes copied per transfer (1..256).
- START_DELAY, 2, M-cycles between the FF46 write and the first source read (>=1).

Ports:
- clk        in   1   system clock (tclk domain)
- rst        in   1   asynchronous, active-low reset
- mcyc_ce    in   1   one-clk pulse marking each M-cycle boundary
- reg_we     in   1   one-clk write strobe for FF46 (address already decoded)
- reg_wdata  in   8   FF46 write data (source page)
- reg_rdata  out  8   FF46 readback
- src_addr   out  16  source bus address
- src_re     out  1   source read request (level, held for the whole M-cycle)
- src_rdata  in   8   source data, valid when sampled on an mcyc_ce clk
- oam_addr   out  8   OAM byte index
- oam_wdata  out  8   OAM write data
- oam_we     out  1   OAM write strobe, one clk wide
- busy       out  1   DMA owns the bus (arbiter grant)
- oam_lock   out  1   OAM inaccessible to PPU and CPU

Behaviour:
- Reset (async, rst=0):
  - state IDLE; page 8'hFF; reg_rdata 8'hFF.
  - src_addr, src_re, oam_addr, oam_wdata, oam_we, busy, oam_lock all 0.
  - Asserting reset mid-transfer aborts immediately; no further oam_we.
- States: IDLE, WAIT, XFER.
  - Internal: dly counter, clog2(START_DELAY+1) bits; idx, 8 bits; restart flag.
- reg_we, from any state:
  - On that clk: page<=reg_wdata, reg_rdata<=reg_wdata, state<=WAIT, dly<=START_DELAY, idx<=0.
  - restart<=1 if the prior state was XFER or WAIT-with-restart, otherwise 0.
  - reg_we takes priority over a coincident mcyc_ce: that M-cycle's pending OAM write is dropped and idx is not advanced.
- WAIT:
  - On each mcyc_ce, dly decrements.
  - On the mcyc_ce where dly==1, state<=XFER.
  - src_re=0.
  - busy = oam_lock = restart (the bus stays held across a restart).
- XFER:
  - src_addr = {page_eff, idx}, src_re=1, busy=1, oam_lock=1.
  - page_eff = page - 8'h20 when page >= 8'hE0 (echo-RAM mirror), otherwise page.
  - On each mcyc_ce clk edge:
    - oam_wdata<=src_rdata, oam_addr<=idx, oam_we<=1 (high for the next clk only).
    - If idx==LEN-1: state<=IDLE and restart<=0. Otherwise idx<=idx+1.
- IDLE: src_re=0, busy=0, oam_lock=0.
- oam_we is deasserted on every clk where it was not set as described above.
- Latency, with mcyc_ce pulses counted after the reg_we clk:
  - First oam_we follows the (START_DELAY+1)th pulse.
  - Last oam_we follows the (START_DELAY+LEN)th pulse.
  - busy falls on the same edge that asserts the last oam_we.
- Width rules:
  - idx compares against LEN-1 only; no 8-bit wrap occurs for LEN<=256.
  - src_addr low byte = idx; high byte = page_eff.
- reg_we and reset together: reset wins (asynchronous).
- reg_we with no mcyc_ce pulses arriving: the block stays in WAIT indefinitely with no timeout.

Decomposition:
- Shared package gb_pkg:
  - localparams DMA_REG_ADDR=16'hFF46, OAM_BASE=16'hFE00, OAM_DMA_LEN=160, ECHO_PAGE_LO=8'hE0.
  - typedef enum logic [1:0] dma_state_t {IDLE, WAIT, XFER}.
- No sub-module: one flat FSM plus counters. The arbiter in dmg_main consumes `busy`; that arbiter is not part of this block.

Test Plan:
- Basic copy: mcyc_ce every 4 clk; src model returns data = addr[7:0]^8'h5A; reg_we with 8'hC1 -> no oam_we for 2 M-cycles; then 160 oam_we pulses with oam_addr 0..159 and oam_wdata = idx^8'h5A; src_addr 16'hC100..16'hC19F; busy high exactly 160 M-cycles; reg_rdata=8'hC1.
- Echo mirror: write 8'hE3 -> src_addr high byte = 8'hC3 throughout; reg_rdata=8'hE3.
- Restart mid-transfer: write 8'hC0, then at idx=50 write 8'hD0 -> busy stays 1 continuously; no oam_we for 2 M-cycles; then idx restarts at 0 with src_addr 16'hD000; 160 further writes.
- Collision: reg_we on the same clk as mcyc_ce during XFER idx=10 -> no oam_we for idx 10; state WAIT; restart=1.
- Reset mid-transfer: rst low at idx=80 -> oam_we, busy, src_re drop to 0 immediately; reg_rdata=8'hFF; after release, no activity until the next reg_we.
- Parameter sweep LEN=1, START_DELAY=1 -> single oam_we after the 2nd mcyc_ce; busy high for exactly 1 M-cycle.
